// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter that shares one combinational palette lookup among N_REQ
// sprite requesters and registers each result in a one-entry valid/ready stage.
module palette_lookup_arbiter #(
  parameter int          N_REQ   = 4,
  parameter int          IDX_W   = 4,
  parameter logic [11:0] KEY_RGB = 12'hF0F
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*IDX_W-1:0]     req_index,
  output logic [N_REQ-1:0]           req_ready,
  output logic [IDX_W-1:0]           pal_index,
  input  logic [3:0]                 pal_red,
  input  logic [3:0]                 pal_green,
  input  logic [3:0]                 pal_blue,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [3:0]                 rsp_red,
  output logic [3:0]                 rsp_green,
  output logic [3:0]                 rsp_blue,
  output logic                       rsp_transparent
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   winner;
  logic [ID_W:0]     cand;
  logic              any_req;
  logic              can_accept;
  logic              grant;
  logic [IDX_W-1:0]  last_q;
  logic [11:0]       pal_rgb;

  // Rotating priority search starting at ptr_q; the first valid requester wins.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    any_req = 1'b0;
    winner  = ptr_q;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!any_req && req_valid[cand[ID_W-1:0]]) begin
        any_req = 1'b1;
        winner  = cand[ID_W-1:0];
      end
    end
  end

  assign rsp_valid  = (state_q == FULL) && !Reset;
  assign can_accept = !rsp_valid || rsp_ready;
  assign grant      = !Reset && any_req && can_accept;
  assign req_ready  = grant ? (N_REQ'(1) << winner) : '0;
  assign pal_rgb    = {pal_red, pal_green, pal_blue};

  // The palette index follows the winner even while stalled, and otherwise parks
  // on the last driven value so the shared palette input never jumps needlessly.
  assign pal_index = Reset   ? '0 :
                     any_req ? req_index[winner*IDX_W +: IDX_W] : last_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (grant) begin
      state_d = FULL;
      ptr_d   = (winner == ID_W'(N_REQ-1)) ? '0 : winner + 1'b1;
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the combinational logic above.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= EMPTY;
      ptr_q           <= '0;
      last_q          <= '0;
      rsp_id          <= '0;
      rsp_red         <= '0;
      rsp_green       <= '0;
      rsp_blue        <= '0;
      rsp_transparent <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (any_req) last_q <= pal_index;
      if (grant) begin
        rsp_id          <= winner;
        rsp_red         <= pal_red;
        rsp_green       <= pal_green;
        rsp_blue        <= pal_blue;
        rsp_transparent <= (pal_rgb == KEY_RGB);
      end
    end
  end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: directed vector table for the listed scenarios,
// then randomized traffic checked against a queue-based round-robin model.
module tb_palette_lookup_arbiter;

  logic        Clk;
  logic        Reset;
  logic [3:0]  req_valid;
  logic [15:0] req_index;
  logic [3:0]  req_ready;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_red, rsp_green, rsp_blue;
  logic        rsp_transparent;

  palette_lookup_arbiter #(.N_REQ(4), .IDX_W(4), .KEY_RGB(12'hF0F)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_red(rsp_red), .rsp_green(rsp_green), .rsp_blue(rsp_blue),
    .rsp_transparent(rsp_transparent)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Palette contents; only entries 1 and 15 hold the magenta key.
  logic [11:0] pal_mem [16];
  initial begin
    pal_mem[0]  = 12'h000; pal_mem[1]  = 12'hF0F; pal_mem[2]  = 12'h123; pal_mem[3]  = 12'h456;
    pal_mem[4]  = 12'hD84; pal_mem[5]  = 12'hF00; pal_mem[6]  = 12'h789; pal_mem[7]  = 12'hABC;
    pal_mem[8]  = 12'h0F0; pal_mem[9]  = 12'h00F; pal_mem[10] = 12'hFF0; pal_mem[11] = 12'h0FF;
    pal_mem[12] = 12'h888; pal_mem[13] = 12'h321; pal_mem[14] = 12'hE0F; pal_mem[15] = 12'hF0F;
  end
  assign {pal_red, pal_green, pal_blue} = pal_mem[pal_index];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the output stage should hold, and the pointer.
  int         m_ptr;
  logic       m_valid;
  int         m_id;
  logic [11:0] m_rgb;
  logic       m_tr;
  logic [3:0] m_last;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    int order[$];
    for (int k = 0; k < 4; k++) order.push_back((p + k) % 4);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_rgb = 12'h000; m_tr = 1'b0; m_last = 4'h0;
  endtask

  task automatic drive(input logic rst, input logic [3:0] v, input logic [15:0] ix, input logic rr);
    Reset = rst; req_valid = v; req_index = ix; rsp_ready = rr;
    #1;
  endtask

  // Checks the current cycle against the model, then advances one clock.
  task automatic model_step();
    int         w;
    logic       granted;
    logic [3:0] e_ready;
    logic [3:0] e_pal;
    w       = Reset ? -1 : rr_pick(req_valid, m_ptr);
    granted = (w >= 0) && (!m_valid || rsp_ready);
    e_ready = granted ? (4'b0001 << w) : 4'b0000;
    e_pal   = Reset ? 4'h0 : (w >= 0) ? req_index[4*w +: 4] : m_last;
    check("model_req_ready", 32'(req_ready), 32'(e_ready));
    check("model_pal_index", 32'(pal_index), 32'(e_pal));
    check("model_rsp_valid", 32'(rsp_valid), 32'(Reset ? 1'b0 : m_valid));
    check("model_rsp_id",    32'(rsp_id), 32'(m_id));
    check("model_rsp_rgb",   32'({rsp_red, rsp_green, rsp_blue}), 32'(m_rgb));
    check("model_rsp_tr",    32'(rsp_transparent), 32'(m_tr));
    @(posedge Clk);
    if (Reset) model_reset();
    else begin
      if (w >= 0) m_last = req_index[4*w +: 4];
      if (granted) begin
        m_valid = 1'b1;
        m_id    = w;
        m_rgb   = pal_mem[req_index[4*w +: 4]];
        m_tr    = (m_rgb == 12'hF0F);
        m_ptr   = (w + 1) % 4;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
    @(negedge Clk);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] idx;
    logic        rready;
    logic [3:0]  e_ready;
    logic [3:0]  e_pal;
    logic        e_valid;
    logic [1:0]  e_id;
    logic [11:0] e_rgb;
    logic        e_tr;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  initial begin
    // rst valid idx rready | ready pal valid id rgb tr (registered fields as seen before the edge)
    vecs[0]  = '{1'b1, 4'h0, 16'h0000, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 12'h000, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 16'h0000, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 12'h000, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 12'h000, 1'b0};
    vecs[3]  = '{1'b0, 4'h4, 16'h0400, 1'b1, 4'h4, 4'h4, 1'b0, 2'd0, 12'h000, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 4'h4, 1'b1, 2'd2, 12'hD84, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b0, 2'd2, 12'hD84, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 16'h7632, 1'b1, 4'h1, 4'h2, 1'b0, 2'd0, 12'h000, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 16'h7632, 1'b1, 4'h2, 4'h3, 1'b1, 2'd0, 12'h123, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 16'h7632, 1'b1, 4'h4, 4'h6, 1'b1, 2'd1, 12'h456, 1'b0};
    vecs[9]  = '{1'b0, 4'hF, 16'h7632, 1'b1, 4'h8, 4'h7, 1'b1, 2'd2, 12'h789, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 16'h7632, 1'b1, 4'h1, 4'h2, 1'b1, 2'd3, 12'hABC, 1'b0};
    vecs[11] = '{1'b0, 4'hF, 16'h7632, 1'b1, 4'h2, 4'h3, 1'b1, 2'd0, 12'h123, 1'b0};
    vecs[12] = '{1'b0, 4'hF, 16'h7632, 1'b1, 4'h4, 4'h6, 1'b1, 2'd1, 12'h456, 1'b0};
    vecs[13] = '{1'b0, 4'hF, 16'h7632, 1'b1, 4'h8, 4'h7, 1'b1, 2'd2, 12'h789, 1'b0};
    vecs[14] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 4'h7, 1'b1, 2'd3, 12'hABC, 1'b0};
    vecs[15] = '{1'b0, 4'h1, 16'h0008, 1'b0, 4'h1, 4'h8, 1'b0, 2'd3, 12'hABC, 1'b0};
    vecs[16] = '{1'b0, 4'h1, 16'h0008, 1'b0, 4'h0, 4'h8, 1'b1, 2'd0, 12'h0F0, 1'b0};
    vecs[17] = '{1'b0, 4'h1, 16'h0008, 1'b0, 4'h0, 4'h8, 1'b1, 2'd0, 12'h0F0, 1'b0};
    vecs[18] = '{1'b0, 4'h1, 16'h0008, 1'b1, 4'h1, 4'h8, 1'b1, 2'd0, 12'h0F0, 1'b0};
    vecs[19] = '{1'b0, 4'h2, 16'h0010, 1'b1, 4'h2, 4'h1, 1'b1, 2'd0, 12'h0F0, 1'b0};
    vecs[20] = '{1'b0, 4'h2, 16'h00F0, 1'b1, 4'h2, 4'hF, 1'b1, 2'd1, 12'hF0F, 1'b1};
    vecs[21] = '{1'b0, 4'h2, 16'h0050, 1'b1, 4'h2, 4'h5, 1'b1, 2'd1, 12'hF0F, 1'b1};
    vecs[22] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 4'h5, 1'b1, 2'd1, 12'hF00, 1'b0};
    vecs[23] = '{1'b0, 4'h4, 16'h0400, 1'b0, 4'h4, 4'h4, 1'b0, 2'd1, 12'hF00, 1'b0};
    vecs[24] = '{1'b1, 4'h9, 16'hC009, 1'b0, 4'h0, 4'h0, 1'b0, 2'd2, 12'hD84, 1'b0};
    vecs[25] = '{1'b0, 4'h9, 16'hC009, 1'b1, 4'h1, 4'h9, 1'b0, 2'd0, 12'h000, 1'b0};
    vecs[26] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 4'h9, 1'b1, 2'd0, 12'h00F, 1'b0};

    Reset = 1'b1; req_valid = '0; req_index = '0; rsp_ready = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    model_reset();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].idx, vecs[i].rready);
      check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_pal_index", i), 32'(pal_index), 32'(vecs[i].e_pal));
      check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_rsp_id", i),    32'(rsp_id), 32'(vecs[i].e_id));
      check($sformatf("vec%0d_rsp_rgb", i),   32'({rsp_red, rsp_green, rsp_blue}), 32'(vecs[i].e_rgb));
      check($sformatf("vec%0d_rsp_tr", i),    32'(rsp_transparent), 32'(vecs[i].e_tr));
      model_step();
    end

    for (int i = 0; i < 800; i++) begin
      logic       r;
      logic [3:0] v;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      drive(r, v, 16'($urandom), ($urandom_range(0, 3) != 0));
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/palette_lookup_arbiter.md
# palette_lookup_arbiter

Shares one combinational 16-entry palette lookup (4-bit index in, 4/4/4-bit RGB out) among several sprite pixel requesters, e.g. fighter body, projectile pulse and effect layers. Round-robin arbitration, one lookup per clock. Each result is held in a one-entry registered output stage with valid/ready backpressure. The block sits between the sprite renderers and the shared palette module, and flags the magenta colour key as transparent for the compositor downstream.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8
- IDX_W, 4: palette index width
- KEY_RGB, 12'hF0F: colour treated as transparent, as {red, green, blue}

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  per-requester lookup request
- req_index  in  N_REQ*IDX_W  requester i index in bits [i*IDX_W +: IDX_W]
- req_ready  out  N_REQ  one-hot grant; combinational from state and inputs
- pal_index  out  IDX_W  index driven to the shared palette module
- pal_red, pal_green, pal_blue  in  4 each  palette response, combinational from pal_index
- rsp_valid  out  1  output stage holds a result
- rsp_ready  in  1  downstream accepts the result
- rsp_id  out  $clog2(N_REQ)  requester that owns the result
- rsp_red, rsp_green, rsp_blue  out  4 each  looked-up colour
- rsp_transparent  out  1  1 when {rsp_red, rsp_green, rsp_blue} == KEY_RGB

## Operation
- can_accept = !rsp_valid || rsp_ready, meaning the output stage is empty or is being drained this cycle.
- Round-robin pointer ptr, range 0..N_REQ-1. The winner is the first i with req_valid[i] set, searching ptr, ptr+1, … with wrap modulo N_REQ.
- Grant occurs only when can_accept is 1 and at least one req_valid bit is set:
  - req_ready[winner]=1; all other req_ready bits are 0.
  - The transfer completes that cycle.
- When no grant occurs, req_ready is all zero.
- pal_index = req_index[winner] whenever a winner exists; otherwise pal_index holds its last driven value. It never glitches to an unrelated requester within a cycle.
- On a grant, the output stage loads:
  - rsp_id = winner
  - rsp_red/green/blue = pal_* sampled in the same cycle
  - rsp_transparent = (pal_* == KEY_RGB)
  - rsp_valid = 1
  - ptr = (winner+1) mod N_REQ
- No grant and rsp_ready=1 with rsp_valid=1: rsp_valid goes to 0.
- No grant and rsp_ready=0: the output stage and ptr hold. rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
- No requests: ptr unchanged.
- A requester may drop req_valid without being granted. This has no side effect.
- Indices 1 and 15 of the current palette both map to F0F, so both report transparent.
- Two-state arbiter view:
  - EMPTY (rsp_valid=0) goes to FULL on grant.
  - FULL goes to FULL on a grant with rsp_ready=1, or while stalled.
  - FULL goes to EMPTY on rsp_ready=1 with no grant.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_red/green/blue=0, rsp_transparent=0, ptr=0, pal_index=0. req_ready is all zero during the Reset cycle.
- Reset asserted mid-stream: the pending result is discarded and no grant is issued in that cycle. Arbitration restarts from requester 0 on the first cycle after Reset deasserts.
- Latency: the grant in cycle t gives rsp_valid=1 with data in cycle t+1.
- Throughput: 1 lookup per clock while rsp_ready is held 1.
- Simultaneous drain and grant in the same cycle: the new result replaces the old with no bubble.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once per N_REQ grants.

## Test plan
- Reset then idle:
  - Stimulus: Reset for 2 cycles, all req_valid=0.
  - Required: rsp_valid=0, req_ready=0, pal_index=0 on every cycle.
- Single requester:
  - Stimulus: req_valid=4'b0100, index 4, palette returns D/8/4, rsp_ready=1.
  - Required: req_ready=4'b0100 in the same cycle. Next cycle rsp_valid=1, rsp_id=2, rsp_red/green/blue=D/8/4, rsp_transparent=0.
- Round-robin fairness:
  - Stimulus: all four valid for 8 cycles, rsp_ready=1.
  - Required: grant order 0,1,2,3,0,1,2,3, with rsp_id following one cycle later.
- Backpressure:
  - Stimulus: requester 0 valid, rsp_ready=0 for 3 cycles, then 1.
  - Required: one grant only. rsp_* stable for 3 cycles, req_ready=0 while stalled, next grant in the cycle rsp_ready rises.
- Transparency:
  - Stimulus: index 1 with response F/0/F, then index 15 with F/0/F, then index 5 with F/0/0.
  - Required: rsp_transparent = 1, 1, 0.
- Reset mid-operation:
  - Stimulus: after a grant to requester 2 with rsp_valid=1, pulse Reset for one cycle while requesters 0 and 3 are valid.
  - Required: rsp_valid=0 and req_ready=0 in the Reset cycle; requester 0 is granted on the next cycle.
